// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction and data requesters share one downstream
// memory port, one outstanding transaction at a time, round-robin on contention.
//
//   state | meaning
//   IDLE  | no transaction; strobes low; grant decided at next edge
//   I_ACT | instruction read in flight, waiting for mem_resp
//   D_ACT | data read or write in flight, waiting for mem_resp
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, I_ACT, D_ACT} state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;

  logic i_req;
  logic d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      write_q      <= write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    write_d      = write_q;
    case (state_q)
      IDLE: begin
        // On contention the side that did not win last time goes first.
        if (i_req && (!d_req || last_grant_q == GRANT_DATA)) begin
          state_d      = I_ACT;
          last_grant_d = GRANT_INST;
          addr_d       = i_addr;
          be_d         = 4'b1111;
          write_d      = 1'b0;
        end else if (d_req) begin
          state_d      = D_ACT;
          last_grant_d = GRANT_DATA;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          write_d      = d_write;
          be_d         = d_write ? d_wmask : 4'b1111;
        end
      end
      I_ACT, D_ACT: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read        = (state_q == I_ACT) | ((state_q == D_ACT) & ~write_q);
  assign mem_write       = (state_q == D_ACT) & write_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;

  assign i_resp  = (state_q == I_ACT) & mem_resp;
  assign d_resp  = (state_q == D_ACT) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written contention and
// async-reset sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, wd;
    logic [3:0]  wm;
    logic        mr;
    logic [31:0] mrd;
    logic        e_rd, e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_ir, e_dr;
  } vec_t;

  vec_t vt[16];

  // Randomized-phase reference: who owns the port, who won last, and the command
  // that was captured when the port was handed out.
  int          owner;
  bit          last_was_data;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  bit          cmd_write;
  bit          i_pend, d_pend;

  initial begin
    // ir dr dw ia da wd wm mr mrd | e_rd e_wr e_addr e_be e_wd e_ir e_dr
    vt[0]  = '{1'b1,1'b0,1'b0,32'h60, 32'h0,   32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,32'h0,   4'h0,32'h0,        1'b0,1'b0};
    vt[1]  = '{1'b1,1'b0,1'b0,32'h80, 32'h0,   32'h0,        4'h0,1'b0,32'h0,        1'b1,1'b0,32'h60,  4'hF,32'h0,        1'b0,1'b0};
    vt[2]  = '{1'b0,1'b0,1'b0,32'h80, 32'h0,   32'h0,        4'h0,1'b0,32'h0,        1'b1,1'b0,32'h60,  4'hF,32'h0,        1'b0,1'b0};
    vt[3]  = '{1'b0,1'b0,1'b0,32'h80, 32'h0,   32'h0,        4'h0,1'b1,32'h00000013, 1'b1,1'b0,32'h60,  4'hF,32'h0,        1'b1,1'b0};
    vt[4]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,   32'h0,        4'h0,1'b1,32'h77,       1'b0,1'b0,32'h60,  4'hF,32'h0,        1'b0,1'b0};
    vt[5]  = '{1'b0,1'b0,1'b1,32'h0,  32'h1004,32'hDEADBEEF, 4'h3,1'b0,32'h0,        1'b0,1'b0,32'h60,  4'hF,32'h0,        1'b0,1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1,32'h0,  32'h1004,32'hDEADBEEF, 4'h3,1'b0,32'h0,        1'b0,1'b1,32'h1004,4'h3,32'hDEADBEEF, 1'b0,1'b0};
    vt[7]  = '{1'b0,1'b0,1'b1,32'h0,  32'h1004,32'hDEADBEEF, 4'h3,1'b1,32'h0,        1'b0,1'b1,32'h1004,4'h3,32'hDEADBEEF, 1'b0,1'b1};
    vt[8]  = '{1'b1,1'b1,1'b0,32'h100,32'h200, 32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,32'h1004,4'h3,32'h0,        1'b0,1'b0};
    vt[9]  = '{1'b1,1'b1,1'b0,32'h100,32'h200, 32'h0,        4'h0,1'b1,32'hA5,       1'b1,1'b0,32'h100, 4'hF,32'h0,        1'b1,1'b0};
    vt[10] = '{1'b1,1'b1,1'b0,32'h100,32'h200, 32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,32'h100, 4'hF,32'h0,        1'b0,1'b0};
    vt[11] = '{1'b1,1'b1,1'b0,32'h100,32'h200, 32'h0,        4'h0,1'b1,32'h5A,       1'b1,1'b0,32'h200, 4'hF,32'h0,        1'b0,1'b1};
    vt[12] = '{1'b0,1'b1,1'b1,32'h0,  32'h300, 32'h1234,     4'h0,1'b0,32'h0,        1'b0,1'b0,32'h200, 4'hF,32'h0,        1'b0,1'b0};
    vt[13] = '{1'b0,1'b1,1'b1,32'h0,  32'h300, 32'h1234,     4'h0,1'b0,32'h0,        1'b0,1'b1,32'h300, 4'h0,32'h1234,     1'b0,1'b0};
    vt[14] = '{1'b0,1'b1,1'b1,32'h0,  32'h300, 32'h1234,     4'h0,1'b1,32'h9,        1'b0,1'b1,32'h300, 4'h0,32'h1234,     1'b0,1'b1};
    vt[15] = '{1'b0,1'b0,1'b0,32'h0,  32'h0,   32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,32'h300, 4'h0,32'h0,        1'b0,1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check1("reset_mem_read", mem_read, 1'b0);
    check1("reset_mem_write", mem_write, 1'b0);
    check32("reset_addr", mem_address, 32'h0);
    check32("reset_be", 32'(mem_byte_enable), 32'h0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      i_read = vt[i].ir; d_read = vt[i].dr; d_write = vt[i].dw;
      i_addr = vt[i].ia; d_addr = vt[i].da; d_wdata = vt[i].wd; d_wmask = vt[i].wm;
      mem_resp = vt[i].mr; mem_rdata = vt[i].mrd;
      @(negedge clk);
      check1($sformatf("vec%0d_mem_read", i), mem_read, vt[i].e_rd);
      check1($sformatf("vec%0d_mem_write", i), mem_write, vt[i].e_wr);
      check32($sformatf("vec%0d_addr", i), mem_address, vt[i].e_addr);
      check32($sformatf("vec%0d_be", i), 32'(mem_byte_enable), 32'(vt[i].e_be));
      check1($sformatf("vec%0d_i_resp", i), i_resp, vt[i].e_ir);
      check1($sformatf("vec%0d_d_resp", i), d_resp, vt[i].e_dr);
      if (vt[i].e_wr) check32($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_wd);
      if (vt[i].e_ir) check32($sformatf("vec%0d_i_rdata", i), i_rdata, vt[i].mrd);
      if (vt[i].e_dr) check32($sformatf("vec%0d_d_rdata", i), d_rdata, vt[i].mrd);
    end

    // Contention right after reset: data first, then strict alternation
    do_reset();
    i_read = 1'b1; i_addr = 32'h10;
    d_read = 1'b1; d_addr = 32'h20;
    for (int n = 0; n < 4; n++) begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (mem_read || mem_write) begin
          found = 1'b1;
          break;
        end
      end
      check1($sformatf("rr%0d_granted", n), found, 1'b1);
      check32($sformatf("rr%0d_addr", n), mem_address, (n % 2 == 0) ? 32'h20 : 32'h10);
      mem_resp = 1'b1;
      mem_rdata = 32'h1000 + 32'(n);
      #1;
      check1($sformatf("rr%0d_i_resp", n), i_resp, (n % 2 == 1));
      check1($sformatf("rr%0d_d_resp", n), d_resp, (n % 2 == 0));
      @(posedge clk); #1 mem_resp = 1'b0;
      @(negedge clk);
      check1($sformatf("rr%0d_idle_gap", n), mem_read | mem_write, 1'b0);
    end

    // Async reset in the middle of a data write
    do_reset();
    d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check1("arst_write_active", mem_write, 1'b1);
    #1 rst = 1'b0;
    mem_resp = 1'b1;
    #1;
    check1("arst_write_dropped", mem_write, 1'b0);
    check1("arst_no_d_resp", d_resp, 1'b0);
    check32("arst_addr_cleared", mem_address, 32'h0);
    d_write = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check1("arst_late_resp_ignored", d_resp, 1'b0);
    @(posedge clk); #1 mem_resp = 1'b0;
    @(negedge clk);
    check1("arst_stays_idle", mem_read | mem_write, 1'b0);

    // Randomized traffic against the transaction model
    do_reset();
    owner = 0; last_was_data = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_be = '0; cmd_write = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      mem_resp  = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      if (owner == 1) begin
        i_read = 1'($urandom_range(0, 1));
        i_addr = $urandom;
      end else if (!i_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          i_pend = 1'b1; i_read = 1'b1;
        end else begin
          i_read = 1'b0;
        end
        i_addr = $urandom;
      end
      if (owner == 2) begin
        d_read = 1'($urandom_range(0, 1)); d_write = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end else if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          int op;
          op = int'($urandom_range(0, 2));
          d_pend = 1'b1;
          d_read = (op != 1); d_write = (op != 0);
        end else begin
          d_read = 1'b0; d_write = 1'b0;
        end
        d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end

      @(negedge clk);
      check1("rnd_mem_read", mem_read, (owner == 1) || (owner == 2 && !cmd_write));
      check1("rnd_mem_write", mem_write, (owner == 2) && cmd_write);
      check32("rnd_addr", mem_address, cmd_addr);
      check32("rnd_be", 32'(mem_byte_enable), 32'(cmd_be));
      check1("rnd_i_resp", i_resp, (owner == 1) && mem_resp);
      check1("rnd_d_resp", d_resp, (owner == 2) && mem_resp);
      if (owner == 2 && cmd_write) check32("rnd_wdata", mem_wdata, cmd_wdata);
      if (owner == 1 && mem_resp) check32("rnd_i_rdata", i_rdata, mem_rdata);
      if (owner == 2 && mem_resp) check32("rnd_d_rdata", d_rdata, mem_rdata);

      if (owner != 0) begin
        if (mem_resp) begin
          if (owner == 1) i_pend = 1'b0;
          else d_pend = 1'b0;
          owner = 0;
        end
      end else begin
        bit wants_i, wants_d;
        wants_i = i_read;
        wants_d = d_read | d_write;
        if (wants_i && (!wants_d || last_was_data)) begin
          owner = 1; last_was_data = 1'b0;
          cmd_addr = i_addr; cmd_be = 4'hF; cmd_write = 1'b0;
        end else if (wants_d) begin
          owner = 2; last_was_data = 1'b1;
          cmd_addr = d_addr; cmd_wdata = d_wdata; cmd_write = d_write;
          cmd_be = d_write ? d_wmask : 4'hF;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
